// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one consecutive-ones run detector between NUM_REQ serial lanes.
// Optional idle-timeout abort is enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_det_sched #(
    parameter int NUM_REQ  = 4,
    parameter int RUN_LEN  = 4,
    parameter int MAX_BITS = 16,
    parameter int TIMEOUT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         bit_in,
    input  logic [NUM_REQ-1:0]         bit_vld,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       busy,
    output logic                       det,
    output logic [$clog2(NUM_REQ)-1:0] det_id,
    output logic                       done,
    output logic                       tmo
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int RUN_W = $clog2(RUN_LEN);
    localparam int CNT_W = $clog2(MAX_BITS + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(MAX_BITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [1:0]       state;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  cur;
    logic [ID_W-1:0]  pick;
    logic             found;
    logic [RUN_W-1:0] run_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             one_in;
    logic             det_now;
    logic             max_now;
    logic             tmo_now;
    logic             release_now;

    // Round-robin search starting just after the most recently released lane.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign accept  = gnt[cur] & bit_vld[cur];
    assign one_in  = bit_in[cur];
    assign det_now = accept & one_in & (run_cnt == RUN_LAST);
    assign max_now = accept & (bit_cnt == BIT_LAST);

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] idle_cnt;
    logic             tmo_q;

    assign tmo_now = ~accept & (idle_cnt == TMO_LAST);
    assign tmo     = tmo_q;

    // Idle counter only runs while a grant is live; any accepted bit restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            tmo_q <= (state == S_RUN) & tmo_now;
            if (state != S_RUN || accept || tmo_now)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign tmo_now = 1'b0;
    assign tmo     = 1'b0;
`endif

    // The bit accepted on the releasing edge is still counted toward det_now/max_now.
    assign release_now = det_now | max_now | ~req[cur] | tmo_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            det     <= 1'b0;
            det_id  <= '0;
            done    <= 1'b0;
            last    <= ID_W'(NUM_REQ - 1);
            cur     <= '0;
            run_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            det  <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt     <= NUM_REQ'(1) << pick;
                        cur     <= pick;
                        busy    <= 1'b1;
                        run_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        run_cnt <= one_in ? run_cnt + 1'b1 : '0;
                    end
                    if (release_now) begin
                        gnt     <= '0;
                        done    <= 1'b1;
                        last    <= cur;
                        run_cnt <= '0;
                        bit_cnt <= '0;
                        det     <= det_now;
                        if (det_now)
                            det_id <= cur;
                        state   <= S_REL;
                    end
                end
                S_REL: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed testbench for seq_det_sched with hand-computed expectations.
// Define SEQ_DET_TIMEOUT_EN for both files to exercise the timeout build.
module tb_seq_det_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] bit_in;
    logic [3:0] bit_vld;
    logic [3:0] gnt;
    logic       busy;
    logic       det;
    logic [1:0] det_id;
    logic       done;
    logic       tmo;

    int vec_count  = 0;
    int miss_count = 0;

    seq_det_sched #(
        .NUM_REQ (4),
        .RUN_LEN (4),
        .MAX_BITS(16),
        .TIMEOUT (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .bit_in (bit_in),
        .bit_vld(bit_vld),
        .gnt    (gnt),
        .busy   (busy),
        .det    (det),
        .det_id (det_id),
        .done   (done),
        .tmo    (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] b, input logic [3:0] v);
        req     = r;
        bit_in  = b;
        bit_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vec_count++;
        if (got !== want) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    initial begin
        logic [6:0] t3_bits;
        t3_bits = 7'b1111011;

        rst     = 1'b1;
        req     = '0;
        bit_in  = '0;
        bit_vld = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_det", 32'(det), 32'h0);
        checkOutput("rst_det_id", 32'(det_id), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_tmo", 32'(tmo), 32'h0);
        rst = 1'b0;

        // Reset mid-grant, then lane 0 wins first against lane 2
        applyStimulus(4'b0100, 4'b0000, 4'b0000);
        checkOutput("t1_gnt2", 32'(gnt), 32'h4);
        checkOutput("t1_busy", 32'(busy), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_async_gnt", 32'(gnt), 32'h0);
        checkOutput("t1_async_busy", 32'(busy), 32'h0);
        #1 rst = 1'b0;
        applyStimulus(4'b0101, 4'b0000, 4'b0000);
        checkOutput("t1_first_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t1_rel_gnt", 32'(gnt), 32'h0);
        checkOutput("t1_rel_done", 32'(done), 32'h1);
        checkOutput("t1_rel_busy", 32'(busy), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t1_idle_done", 32'(done), 32'h0);
        checkOutput("t1_idle_busy", 32'(busy), 32'h0);

        // Lane 1 sends four ones
        applyStimulus(4'b0010, 4'b0000, 4'b0000);
        checkOutput("t2_gnt", 32'(gnt), 32'h2);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(4'b0010, 4'b0010, 4'b0010);
            checkOutput($sformatf("t2_det_%0d", k), 32'(det), (k == 4) ? 32'h1 : 32'h0);
        end
        checkOutput("t2_det_id", 32'(det_id), 32'h1);
        checkOutput("t2_done", 32'(done), 32'h1);
        checkOutput("t2_gnt_rel", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t2_det_pulse", 32'(det), 32'h0);
        checkOutput("t2_det_id_hold", 32'(det_id), 32'h1);

        // Lane 0 sends 1,1,0,1,1,1,1 while other lanes shout ones
        applyStimulus(4'b0001, 4'b0000, 4'b0000);
        checkOutput("t3_gnt", 32'(gnt), 32'h1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(4'b0001, {3'b111, t3_bits[k]}, 4'b1111);
            checkOutput($sformatf("t3_det_%0d", k + 1), 32'(det), (k == 6) ? 32'h1 : 32'h0);
        end
        checkOutput("t3_det_id", 32'(det_id), 32'h0);
        checkOutput("t3_done", 32'(done), 32'h1);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);

        // Lane 2 drops req on the same cycle as its fourth one
        applyStimulus(4'b0100, 4'b0000, 4'b0000);
        checkOutput("t5_gnt", 32'(gnt), 32'h4);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(4'b0100, 4'b0100, 4'b0100);
            checkOutput($sformatf("t5_det_%0d", k), 32'(det), 32'h0);
        end
        applyStimulus(4'b0000, 4'b0100, 4'b0100);
        checkOutput("t5_det", 32'(det), 32'h1);
        checkOutput("t5_det_id", 32'(det_id), 32'h2);
        checkOutput("t5_done", 32'(done), 32'h1);
        checkOutput("t5_gnt_rel", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t5_busy", 32'(busy), 32'h0);

        // Lane 3 granted but never sends a bit
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
        checkOutput("t6_gnt", 32'(gnt), 32'h8);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(4'b1000, 4'b0000, 4'b0000);
            checkOutput($sformatf("t6_gnt_%0d", k), 32'(gnt), 32'h8);
            checkOutput($sformatf("t6_tmo_%0d", k), 32'(tmo), 32'h0);
        end
        applyStimulus(4'b1000, 4'b0000, 4'b0000);
`ifdef SEQ_DET_TIMEOUT_EN
        checkOutput("t6_tmo", 32'(tmo), 32'h1);
        checkOutput("t6_done", 32'(done), 32'h1);
        checkOutput("t6_det", 32'(det), 32'h0);
        checkOutput("t6_gnt_rel", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t6_tmo_pulse", 32'(tmo), 32'h0);
        checkOutput("t6_busy", 32'(busy), 32'h0);
`else
        checkOutput("t6_gnt_held", 32'(gnt), 32'h8);
        checkOutput("t6_tmo_off", 32'(tmo), 32'h0);
        checkOutput("t6_done_off", 32'(done), 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1000, 4'b0000, 4'b0000);
            checkOutput($sformatf("t6_hold_%0d", k), 32'(gnt), 32'h8);
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t6_drop_done", 32'(done), 32'h1);
        checkOutput("t6_drop_gnt", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0000);
        checkOutput("t6_busy", 32'(busy), 32'h0);
`endif

        // All lanes requesting zeros: grants rotate 0,1,2,3,0 after 16 bits each
        for (int g = 0; g < 5; g++) begin
            applyStimulus(4'b1111, 4'b0000, 4'b1111);
            checkOutput($sformatf("t4_gnt_%0d", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
            for (int b = 1; b <= 16; b++) begin
                applyStimulus(4'b1111, 4'b0000, 4'b1111);
                if (b == 15)
                    checkOutput($sformatf("t4_hold_%0d", g), 32'(gnt), 32'(4'b0001 << (g % 4)));
            end
            checkOutput($sformatf("t4_done_%0d", g), 32'(done), 32'h1);
            checkOutput($sformatf("t4_rel_%0d", g), 32'(gnt), 32'h0);
            checkOutput($sformatf("t4_det_%0d", g), 32'(det), 32'h0);
            applyStimulus(4'b1111, 4'b0000, 4'b1111);
            checkOutput($sformatf("t4_idle_%0d", g), 32'(busy), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
